// File: rtl/ysyx_22040125_branch_redirect_ctrl_pkg.sv
// Shared encodings for the branch redirect controller: PC mux select codes
// and the redirect FSM state codes.
package ysyx_22040125_branch_redirect_ctrl_pkg;

  localparam logic [2:0] PC_SEL_SEQ    = 3'b000;
  localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
  localparam logic [2:0] PC_SEL_JAL    = 3'b011;
  localparam logic [2:0] PC_SEL_JALR   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } redir_state_e;

endpackage

// File: rtl/ysyx_22040125_sat_counter.sv
// Saturating up-counter: clears on clr, increments on inc, sticks at all-ones.
module ysyx_22040125_sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // Count events, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= sat_inc(value);
    end
  end

endmodule

// File: rtl/ysyx_22040125_branch_redirect_ctrl.sv
// Branch/jump redirect sequencer between EX and the IF PC mux.
// Latches a resolved redirect, holds it to fetch until accepted, then flushes
// IF/ID for FLUSH_CYCLES cycles; EX is stalled the whole time.
// Optional: define BRANCH_REDIRECT_PERF_EN to add saturating counters of
// accepted redirects and stall cycles.
module ysyx_22040125_branch_redirect_ctrl
  import ysyx_22040125_branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int PC_SEL_W     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid_i,
  input  logic [PC_SEL_W-1:0] ex_pc_sel_i,
  input  logic [XLEN-1:0]     ex_target_i,
  output logic                ex_ready_o,
  output logic                stall_o,
  output logic                redirect_valid_o,
  input  logic                redirect_ready_i,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic [PC_SEL_W-1:0] pc_sel_o,
  output logic                flush_o
`ifdef BRANCH_REDIRECT_PERF_EN
  ,
  output logic [63:0]         perf_redirect_cnt_o,
  output logic [63:0]         perf_stall_cnt_o
`endif
);

  localparam int CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_INIT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  redir_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load;
  logic [PC_SEL_W-1:0] sel_p0;
  logic [XLEN-1:0]     target_p0;

  // Next-state logic: take a redirect only from IDLE, leave REDIRECT on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && (ex_pc_sel_i != PC_SEL_W'(PC_SEL_SEQ))) begin
          load    = 1'b1;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_INIT);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, flush counter and latched redirect; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_p0    <= '0;
      target_p0 <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        sel_p0    <= ex_pc_sel_i;
        target_p0 <= ex_target_i;
      end
    end
  end

  // Outputs are decoded purely from registered state and latched data.
  always_comb begin
    ex_ready_o       = (state_q == ST_IDLE);
    stall_o          = (state_q != ST_IDLE);
    redirect_valid_o = (state_q == ST_REDIRECT);
    flush_o          = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
    pc_sel_o         = (state_q == ST_REDIRECT) ? sel_p0 : '0;
    redirect_pc_o    = target_p0;
  end

`ifdef BRANCH_REDIRECT_PERF_EN
  ysyx_22040125_sat_counter #(.W(64)) u_perf_redirect (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_valid_o & redirect_ready_i),
    .clr   (1'b0),
    .value (perf_redirect_cnt_o)
  );

  ysyx_22040125_sat_counter #(.W(64)) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_o),
    .clr   (1'b0),
    .value (perf_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ysyx_22040125_branch_redirect_ctrl.sv
// Bench for the branch redirect controller: a transaction-level model
// (pending request + remaining flush cycles) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ysyx_22040125_branch_redirect_ctrl;

  localparam int XLEN  = 64;
  localparam int SELW  = 3;
  localparam int FLUSH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid_i = 1'b0;
  logic [SELW-1:0] ex_pc_sel_i = '0;
  logic [XLEN-1:0] ex_target_i = '0;
  logic            ex_ready_o;
  logic            stall_o;
  logic            redirect_valid_o;
  logic            redirect_ready_i = 1'b0;
  logic [XLEN-1:0] redirect_pc_o;
  logic [SELW-1:0] pc_sel_o;
  logic            flush_o;
`ifdef BRANCH_REDIRECT_PERF_EN
  logic [63:0]     perf_redirect_cnt_o;
  logic [63:0]     perf_stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040125_branch_redirect_ctrl #(
    .XLEN(XLEN), .PC_SEL_W(SELW), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .ex_pc_sel_i      (ex_pc_sel_i),
    .ex_target_i      (ex_target_i),
    .ex_ready_o       (ex_ready_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o),
    .pc_sel_o         (pc_sel_o),
    .flush_o          (flush_o)
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    .perf_redirect_cnt_o (perf_redirect_cnt_o),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending request to fetch, then a number of
  // flush cycles left; busy whenever either is outstanding.
  bit          m_pending;
  int          m_flush_left;
  logic [2:0]  m_sel;
  logic [63:0] m_tgt;
  longint      m_acc;
  longint      m_stall;

  function automatic bit m_busy();
    return m_pending || (m_flush_left > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0; m_flush_left = 0; m_sel = '0; m_tgt = '0;
      m_acc = 0; m_stall = 0;
    end else begin
      if (m_busy()) m_stall++;
      if (m_pending) begin
        if (redirect_ready_i) begin
          m_pending    = 0;
          m_flush_left = FLUSH;
          m_acc++;
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (ex_valid_i && ex_pc_sel_i != 3'b000) begin
        m_pending = 1;
        m_sel     = ex_pc_sel_i;
        m_tgt     = ex_target_i;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("model_ex_ready", 64'(ex_ready_o), 64'(!m_busy()));
    chk("model_stall", 64'(stall_o), 64'(m_busy()));
    chk("model_valid", 64'(redirect_valid_o), 64'(m_pending));
    chk("model_flush", 64'(flush_o), 64'(m_busy()));
    chk("model_pc_sel", 64'(pc_sel_o), m_pending ? 64'(m_sel) : 64'd0);
    if (m_pending || !rst_n) chk("model_redirect_pc", redirect_pc_o, m_tgt);
`ifdef BRANCH_REDIRECT_PERF_EN
    chk("model_perf_redirect", perf_redirect_cnt_o, 64'(m_acc));
    chk("model_perf_stall", perf_stall_cnt_o, 64'(m_stall));
`endif
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic request(input logic [2:0] sel, input logic [63:0] tgt, input logic rdy);
    ex_valid_i = 1'b1; ex_pc_sel_i = sel; ex_target_i = tgt; redirect_ready_i = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_ready", 64'(ex_ready_o), 64'd1);
      chk("t1_flush", 64'(flush_o), 64'd0);
      chk("t1_valid", 64'(redirect_valid_o), 64'd0);
      chk("t1_pc", redirect_pc_o, 64'd0);
      chk("t1_sel", 64'(pc_sel_o), 64'd0);
    end

    // 2: branch accepted immediately, two flush cycles, idle at +4
    request(3'b010, 64'h8000_0040, 1'b1);
    step();
    ex_valid_i = 1'b0;
    chk("t2_valid", 64'(redirect_valid_o), 64'd1);
    chk("t2_pc", redirect_pc_o, 64'h8000_0040);
    chk("t2_sel", 64'(pc_sel_o), 64'd2);
    chk("t2_stall", 64'(stall_o), 64'd1);
    step();
    chk("t2_f1_flush", 64'(flush_o), 64'd1);
    chk("t2_f1_valid", 64'(redirect_valid_o), 64'd0);
    chk("t2_f1_sel", 64'(pc_sel_o), 64'd0);
    step();
    chk("t2_f2_flush", 64'(flush_o), 64'd1);
    step();
    chk("t2_idle_ready", 64'(ex_ready_o), 64'd1);
    chk("t2_idle_flush", 64'(flush_o), 64'd0);
    redirect_ready_i = 1'b0;

    // 3: fetch holds off for 5 cycles; new EX results are ignored meanwhile
    request(3'b010, 64'h8000_0040, 1'b0);
    step();
    ex_pc_sel_i = 3'b011; ex_target_i = 64'hDEAD_BEEF;
    for (int i = 1; i <= 5; i++) begin
      chk("t3_valid", 64'(redirect_valid_o), 64'd1);
      chk("t3_pc", redirect_pc_o, 64'h8000_0040);
      chk("t3_sel", 64'(pc_sel_o), 64'd2);
      chk("t3_flush", 64'(flush_o), 64'd1);
      if (i == 5) begin
        redirect_ready_i = 1'b1;
        ex_valid_i = 1'b0;
      end
      step();
    end
    redirect_ready_i = 1'b0;
    chk("t3_accepted", 64'(redirect_valid_o), 64'd0);
    chk("t3_flush_after", 64'(flush_o), 64'd1);
    step(); step();
    chk("t3_idle", 64'(ex_ready_o), 64'd1);

    // 4: sequential pc_sel is consumed without a redirect
    request(3'b000, 64'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_flush", 64'(flush_o), 64'd0);
      chk("t4_ready", 64'(ex_ready_o), 64'd1);
      chk("t4_valid", 64'(redirect_valid_o), 64'd0);
    end
    ex_valid_i = 1'b0; redirect_ready_i = 1'b0;

    // 5: async reset during REDIRECT, then a clean new request
    request(3'b100, 64'h8000_0100, 1'b0);
    step();
    ex_valid_i = 1'b0;
    chk("t5_pre_valid", 64'(redirect_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(redirect_valid_o), 64'd0);
    chk("t5_rst_flush", 64'(flush_o), 64'd0);
    chk("t5_rst_sel", 64'(pc_sel_o), 64'd0);
    chk("t5_rst_pc", redirect_pc_o, 64'd0);
    chk("t5_rst_ready", 64'(ex_ready_o), 64'd1);
    chk("t5_rst_stall", 64'(stall_o), 64'd0);
    step();
    rst_n = 1'b1;
    request(3'b100, 64'h8000_1000, 1'b1);
    step();
    ex_valid_i = 1'b0;
    chk("t5_new_valid", 64'(redirect_valid_o), 64'd1);
    chk("t5_new_pc", redirect_pc_o, 64'h8000_1000);
    chk("t5_new_sel", 64'(pc_sel_o), 64'd4);
    step(); step(); step();
    redirect_ready_i = 1'b0;
    chk("t5_new_idle", 64'(ex_ready_o), 64'd1);

`ifdef BRANCH_REDIRECT_PERF_EN
    // 6: three redirects, each with two ready-low cycles, from cleared counters
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      request(3'b010, 64'h8000_0200 + 64'(r * 4), 1'b0);
      step();
      ex_valid_i = 1'b0;
      step();
      step();
      redirect_ready_i = 1'b1;
      step();
      redirect_ready_i = 1'b0;
      step();
      step();
    end
    chk("t6_perf_redirect", perf_redirect_cnt_o, 64'd3);
    chk("t6_perf_stall", perf_stall_cnt_o, 64'd15);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
